// File: rtl/gf180mcu_fd_sc_mcu9t5v0__invbank_sync.sv
`default_nettype none
// ============================================================================
// Module   : gf180mcu_fd_sc_mcu9t5v0__invbank_sync
// Brief    : Registered multi-channel inverter bank with per-channel polarity
//            mask, updated through a draining four-phase handshake.
// Revision : 1.0 - initial release
// ============================================================================
module gf180mcu_fd_sc_mcu9t5v0__invbank_sync #(
    parameter int               WIDTH    = 8,
    parameter int               STAGES   = 2,
    parameter logic [WIDTH-1:0] POL_INIT = {WIDTH{1'b1}}
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] I,
    input  logic             EN,
    output logic [WIDTH-1:0] ZN,
    output logic             ZN_VLD,
    input  logic [WIDTH-1:0] POL,
    input  logic             POL_REQ,
    output logic             POL_ACK,
    output logic             BUSY,
    inout  wire              VDD,
    inout  wire              VSS
);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_DRAIN = 2'd1;
    localparam logic [1:0] c_ST_ACK   = 2'd2;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [WIDTH-1:0] r_pol;
    logic [WIDTH-1:0] r_data [STAGES];
    logic [STAGES-1:0] r_vld;
    logic             w_accept;
    logic             w_empty;
    wire              w_unused_supply;

    // Supply pins are present for the cell footprint only.
    assign w_unused_supply = VDD ^ VSS;

    assign w_accept = EN && (r_state == c_ST_IDLE) && !POL_REQ;
    assign w_empty  = ~|r_vld;

    // Stage 0 only changes on an accepted word, so ZN holds between words.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int s = 0; s < STAGES; s++) begin
                r_data[s] <= '0;
            end
            r_vld <= '0;
        end else begin
            r_vld[0] <= w_accept;
            if (w_accept) begin
                r_data[0] <= I ^ r_pol;
            end
            for (int s = 1; s < STAGES; s++) begin
                r_data[s] <= r_data[s-1];
                r_vld[s]  <= r_vld[s-1];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= c_ST_IDLE;
            r_pol   <= POL_INIT;
        end else begin
            r_state <= w_state_nxt;
            if ((r_state == c_ST_DRAIN) && w_empty) begin
                r_pol <= POL;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE:  if (POL_REQ) w_state_nxt = c_ST_DRAIN;
            c_ST_DRAIN: if (w_empty) w_state_nxt = c_ST_ACK;
            c_ST_ACK:   if (!POL_REQ) w_state_nxt = c_ST_IDLE;
            default:    w_state_nxt = c_ST_IDLE;
        endcase
    end

    assign ZN      = r_data[STAGES-1];
    assign ZN_VLD  = r_vld[STAGES-1];
    assign BUSY    = (r_state != c_ST_IDLE);
    assign POL_ACK = (r_state == c_ST_ACK);

endmodule
`default_nettype wire

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__invbank_sync.sv
`default_nettype none
// ============================================================================
// Module   : tb_gf180mcu_fd_sc_mcu9t5v0__invbank_sync
// Brief    : Scoreboard bench: directed handshake scenarios plus random data
//            on WIDTH/STAGES = 8/2, 1/1 and 32/4.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gf180mcu_fd_sc_mcu9t5v0__invbank_sync;

    localparam int W = 8;
    localparam int S = 2;

    typedef struct {
        logic [31:0] data;
        int          due;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    wire vdd;
    wire vss;
    assign vdd = 1'b1;
    assign vss = 1'b0;

    logic         rst, en, pol_req, mon_off;
    logic [W-1:0] din, pol, pol_m;
    logic [W-1:0] zn;
    logic         zn_vld, pol_ack, busy;
    exp_t         q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    gf180mcu_fd_sc_mcu9t5v0__invbank_sync #(.WIDTH(W), .STAGES(S)) u_dut (
        .CLK(clk), .RST(rst), .I(din), .EN(en), .ZN(zn), .ZN_VLD(zn_vld),
        .POL(pol), .POL_REQ(pol_req), .POL_ACK(pol_ack), .BUSY(busy),
        .VDD(vdd), .VSS(vss)
    );

    // Monitor: every valid output must match the oldest expectation, on time.
    always @(negedge clk) begin
        if (!rst && !mon_off) begin
            if (zn_vld) begin
                if (q.size() == 0) begin
                    chk("unexpected_zn_vld", 32'(zn), 32'hFFFF_FFFF);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("zn_data", 32'(zn), e.data);
                    chk("zn_latency", cyc, e.due);
                end
            end else if (q.size() != 0 && q[0].due <= cyc) begin
                chk("zn_missing", 32'(zn_vld), 32'd1);
                void'(q.pop_front());
            end
        end
    end

    // Requester never changes POL mid-request.
    logic [W-1:0] pol_q;
    logic         req_q = 1'b0;
    always @(posedge clk) begin
        if (req_q && pol_req) assert (pol === pol_q) else $error("POL moved during request");
        pol_q <= pol;
        req_q <= pol_req;
    end

    task automatic send(input logic [W-1:0] d, input logic [W-1:0] e);
        @(negedge clk);
        en  = 1'b1;
        din = d;
        q.push_back('{32'(e), cyc + S});
    endtask

    task automatic nop();
        @(negedge clk);
        en  = 1'b0;
        din = W'($urandom);
    endtask

    task automatic handshake(input logic [W-1:0] newpol, input bit empty);
        int n;
        @(negedge clk);
        pol     = newpol;
        pol_req = 1'b1;
        en      = 1'b1;
        din     = W'($urandom);
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (n == 1) chk("busy_rise", 32'(busy), 32'd1);
            en  = 1'b1;
            din = W'($urandom);
        end while (!pol_ack && n < S + 4);
        chk("ack_seen", 32'(pol_ack), 32'd1);
        if (empty) chk("ack_latency_empty", n, 2);
        else       chk("ack_latency_bound", 32'(n >= 2 && n <= S + 2), 32'd1);
        @(negedge clk);
        chk("ack_held", 32'(pol_ack), 32'd1);
        pol_req = 1'b0;
        en      = 1'b0;
        @(negedge clk);
        chk("ack_fall", 32'(pol_ack), 32'd0);
        chk("busy_fall", 32'(busy), 32'd0);
        pol_m = newpol;
    endtask

    // Extra configurations: random data through one polarity change each.
    for (genvar g = 0; g < 2; g++) begin : g_sweep
        localparam int LW = (g == 0) ? 1 : 32;
        localparam int LS = (g == 0) ? 1 : 4;
        logic          r2, e2, req2, ack2, busy2, vld2;
        logic [LW-1:0] d2, p2, z2, pm2;
        exp_t          q2[$];
        bit            done_sw = 1'b0;

        gf180mcu_fd_sc_mcu9t5v0__invbank_sync #(.WIDTH(LW), .STAGES(LS)) u_sw (
            .CLK(clk), .RST(r2), .I(d2), .EN(e2), .ZN(z2), .ZN_VLD(vld2),
            .POL(p2), .POL_REQ(req2), .POL_ACK(ack2), .BUSY(busy2),
            .VDD(vdd), .VSS(vss)
        );

        always @(negedge clk) begin
            if (!r2) begin
                if (vld2) begin
                    if (q2.size() == 0) begin
                        chk("sw_unexpected_vld", 32'(z2), 32'hFFFF_FFFF);
                    end else begin
                        exp_t e;
                        e = q2.pop_front();
                        chk("sw_data", 32'(z2), e.data);
                        chk("sw_latency", cyc, e.due);
                    end
                end else if (q2.size() != 0 && q2[0].due <= cyc) begin
                    chk("sw_missing", 32'(vld2), 32'd1);
                    void'(q2.pop_front());
                end
            end
        end

        initial begin
            r2 = 1'b1; e2 = 1'b0; d2 = '0; p2 = '0; req2 = 1'b0; pm2 = '1;
            repeat (2) @(negedge clk);
            r2 = 1'b0;
            for (int i = 0; i < 120; i++) begin
                @(negedge clk);
                if (i == 60) begin
                    p2   = LW'($urandom);
                    req2 = 1'b1;
                    e2   = 1'b0;
                    for (int n = 0; n < LS + 4 && !ack2; n++) @(negedge clk);
                    chk("sw_ack", 32'(ack2), 32'd1);
                    req2 = 1'b0;
                    @(negedge clk);
                    chk("sw_idle", 32'(busy2), 32'd0);
                    pm2 = p2;
                end else begin
                    e2 = ($urandom_range(0, 3) != 0);
                    d2 = LW'($urandom);
                    if (e2) q2.push_back('{32'(d2 ^ pm2), cyc + LS});
                end
            end
            @(negedge clk);
            e2 = 1'b0;
            repeat (LS + 2) @(negedge clk);
            chk("sw_drained", q2.size(), 0);
            done_sw = 1'b1;
        end
    end

    initial begin
        rst = 1'b1; en = 1'b0; din = '0; pol = '0; pol_req = 1'b0; mon_off = 1'b1;
        pol_m = '1;
        repeat (2) @(negedge clk);
        chk("rst_zn", 32'(zn), 32'd0);
        chk("rst_zn_vld", 32'(zn_vld), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_pol_ack", 32'(pol_ack), 32'd0);
        rst = 1'b0;
        mon_off = 1'b0;

        // Single word, then a four-word stream.
        send(8'h5A, 8'hA5);
        repeat (3) nop();
        send(8'h00, 8'hFF);
        send(8'hFF, 8'h00);
        send(8'h0F, 8'hF0);
        send(8'h3C, 8'hC3);
        repeat (4) nop();

        // Empty-pipe polarity change.
        handshake(8'h0F, 1'b1);
        send(8'h5A, 8'h55);
        repeat (3) nop();

        // Polarity change with two words in flight.
        send(8'hA1, 8'hAE);
        send(8'hB2, 8'hBD);
        handshake(8'h00, 1'b0);
        send(8'h5A, 8'h5A);
        repeat (3) nop();

        // Request withdrawn during DRAIN: ACK pulses for one cycle.
        send(8'h11, 8'h11);
        send(8'h22, 8'h22);
        @(negedge clk);
        en = 1'b0; pol = 8'h3C; pol_req = 1'b1;
        @(negedge clk);
        chk("viol_busy", 32'(busy), 32'd1);
        pol_req = 1'b0;
        for (int n = 0; n < S + 4 && !pol_ack; n++) @(negedge clk);
        chk("viol_ack", 32'(pol_ack), 32'd1);
        @(negedge clk);
        chk("viol_ack_one_cycle", 32'(pol_ack), 32'd0);
        chk("viol_idle", 32'(busy), 32'd0);
        pol_m = 8'h3C;
        send(8'h5A, 8'h66);
        repeat (3) nop();

        // Reset while draining.
        send(8'h01, 8'h3D);
        send(8'h02, 8'h3E);
        @(negedge clk);
        en = 1'b0; pol = 8'h00; pol_req = 1'b1;
        @(negedge clk);
        chk("drain_busy", 32'(busy), 32'd1);
        mon_off = 1'b1;
        q.delete();
        rst = 1'b1; pol_req = 1'b0;
        @(negedge clk);
        chk("mid_rst_zn_vld", 32'(zn_vld), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_pol_ack", 32'(pol_ack), 32'd0);
        chk("mid_rst_zn", 32'(zn), 32'd0);
        rst = 1'b0;
        mon_off = 1'b0;
        pol_m = 8'hFF;
        send(8'h5A, 8'hA5);
        repeat (3) nop();

        // Random traffic with occasional polarity changes.
        for (int i = 0; i < 150; i++) begin
            int r;
            r = $urandom_range(0, 19);
            if (r < 12) begin
                logic [W-1:0] d;
                d = W'($urandom);
                send(d, d ^ pol_m);
            end else if (r < 19) begin
                nop();
            end else begin
                handshake(W'($urandom), 1'b0);
            end
        end
        repeat (S + 3) nop();
        chk("queue_drained", q.size(), 0);

        for (int i = 0; i < 2000 && !(g_sweep[0].done_sw && g_sweep[1].done_sw); i++)
            @(negedge clk);
        chk("sweep_done", 32'(g_sweep[0].done_sw && g_sweep[1].done_sw), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete, cycle %0d", cyc);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
